// File: rtl/apb_mtimer.sv
// apb_mtimer: APB completer for the 64-bit machine timer (mtime/mtimecmp)
// with an 8-bit prescaler, atomic 64-bit read shadow and a level timer irq.
module apb_mtimer #(
  parameter logic [7:0] PrescaleRst = 8'd0,
  parameter logic       EnableRst   = 1'b0
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic [31:0] paddr_i,
  input  logic        psel_i,
  input  logic        penable_i,
  input  logic        pwrite_i,
  input  logic [31:0] pwdata_i,
  input  logic [3:0]  pstrb_i,
  output logic [31:0] prdata_o,
  output logic        pready_o,
  output logic        pslverr_o,
  output logic        timer_irq_o
);

  localparam logic [11:0] AddrMtimeLo = 12'h000;
  localparam logic [11:0] AddrMtimeHi = 12'h004;
  localparam logic [11:0] AddrCmpLo   = 12'h008;
  localparam logic [11:0] AddrCmpHi   = 12'h00C;
  localparam logic [11:0] AddrCtrl    = 12'h010;
  localparam logic [11:0] AddrStatus  = 12'h014;

  logic [63:0] mtime;
  logic [63:0] mtimecmp;
  logic        enable;
  logic [7:0]  prescale;
  logic [7:0]  pcnt;
  logic [31:0] hi_shadow;
  logic        irq;

  logic [11:0] offset;
  logic        access;
  logic        addr_ok;
  logic        err;
  logic        wr_ok;
  logic        rd_ok;
  logic        wr_mtime_lo;
  logic        wr_mtime_hi;
  logic        wr_cmp_lo;
  logic        wr_cmp_hi;
  logic        wr_ctrl;
  logic        rd_mtime_lo;
  logic        tick;
  logic        unused_paddr;

  // Merge write data into an existing word, one byte per strobe bit.
  function automatic logic [31:0] apply_strobes(input logic [31:0] old_val,
                                                input logic [31:0] new_val,
                                                input logic [3:0]  strb);
    logic [31:0] res;
    res = old_val;
    for (int i = 0; i < 4; i++) begin
      if (strb[i]) res[8*i +: 8] = new_val[8*i +: 8];
    end
    return res;
  endfunction

  // Only the low 12 address bits select a register inside the window.
  assign offset       = paddr_i[11:0];
  assign unused_paddr = ^paddr_i[31:12];
  assign access       = psel_i & penable_i;

  // Recognise the six register offsets; misaligned offsets never match.
  always_comb begin
    case (offset)
      AddrMtimeLo, AddrMtimeHi, AddrCmpLo, AddrCmpHi, AddrCtrl, AddrStatus:
        addr_ok = 1'b1;
      default:
        addr_ok = 1'b0;
    endcase
  end

  // STATUS is read-only, so writing it is an error as well.
  assign err   = access & (~addr_ok | (pwrite_i & (offset == AddrStatus)));
  assign wr_ok = access & pwrite_i & ~err;
  assign rd_ok = access & ~pwrite_i & ~err;

  assign wr_mtime_lo = wr_ok & (offset == AddrMtimeLo);
  assign wr_mtime_hi = wr_ok & (offset == AddrMtimeHi);
  assign wr_cmp_lo   = wr_ok & (offset == AddrCmpLo);
  assign wr_cmp_hi   = wr_ok & (offset == AddrCmpHi);
  assign wr_ctrl     = wr_ok & (offset == AddrCtrl);
  assign rd_mtime_lo = rd_ok & (offset == AddrMtimeLo);

  assign tick = enable & (pcnt == prescale);

  // mtime: a bus write to either half wins over a tick in the same cycle.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      mtime <= 64'd0;
    end else if (wr_mtime_lo) begin
      mtime[31:0] <= apply_strobes(mtime[31:0], pwdata_i, pstrb_i);
    end else if (wr_mtime_hi) begin
      mtime[63:32] <= apply_strobes(mtime[63:32], pwdata_i, pstrb_i);
    end else if (tick) begin
      mtime <= mtime + 64'd1;
    end
  end

  // Prescaler counter: wraps at prescale, held at zero while disabled.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      pcnt <= 8'd0;
    end else if (wr_ctrl || !enable || (pcnt == prescale)) begin
      pcnt <= 8'd0;
    end else begin
      pcnt <= pcnt + 8'd1;
    end
  end

  // CTRL fields, each updated only when its byte strobe is set.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      enable   <= EnableRst;
      prescale <= PrescaleRst;
    end else if (wr_ctrl) begin
      if (pstrb_i[0]) enable   <= pwdata_i[0];
      if (pstrb_i[1]) prescale <= pwdata_i[15:8];
    end
  end

  // Compare value, written one 32-bit half at a time.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      mtimecmp <= 64'hFFFF_FFFF_FFFF_FFFF;
    end else if (wr_cmp_lo) begin
      mtimecmp[31:0] <= apply_strobes(mtimecmp[31:0], pwdata_i, pstrb_i);
    end else if (wr_cmp_hi) begin
      mtimecmp[63:32] <= apply_strobes(mtimecmp[63:32], pwdata_i, pstrb_i);
    end
  end

  // Reading MTIME_LO freezes the upper half so MTIME_HI pairs with it.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      hi_shadow <= 32'd0;
    end else if (rd_mtime_lo) begin
      hi_shadow <= mtime[63:32];
    end
  end

  // Registered level interrupt from the current register contents.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      irq <= 1'b0;
    end else begin
      irq <= (mtime >= mtimecmp);
    end
  end

  // Read data only during a valid read access phase, zero otherwise.
  always_comb begin
    prdata_o = 32'd0;
    if (rd_ok) begin
      case (offset)
        AddrMtimeLo: prdata_o = mtime[31:0];
        AddrMtimeHi: prdata_o = hi_shadow;
        AddrCmpLo:   prdata_o = mtimecmp[31:0];
        AddrCmpHi:   prdata_o = mtimecmp[63:32];
        AddrCtrl:    prdata_o = {16'd0, prescale, 7'd0, enable};
        AddrStatus:  prdata_o = {31'd0, irq};
        default:     prdata_o = 32'd0;
      endcase
    end
  end

  assign pready_o    = 1'b1;
  assign pslverr_o   = err;
  assign timer_irq_o = irq;

endmodule
